// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg: shared types and sizing helpers for the iterative FP square-root unit.
//   state_t : control FSM states
//   f_bias  : exponent bias for a given exponent width
//   f_n_it  : ITER cycles needed for MAN_W+2 root bits at a given steps-per-cycle
//   f_qnan  : canonical quiet NaN pattern (positive, all-ones exponent, top mantissa bit set)
package fp_sqrt_pkg;
    typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;
    function automatic int f_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    function automatic int f_n_it(input int mw, input int spc);
        return (mw + 2 + spc - 1) / spc;
    endfunction
    function automatic logic [127:0] f_qnan(input int ew, input int mw);
        logic [127:0] q = '0;
        for (int i = mw - 1; i < mw + ew; i++) q[i] = 1'b1;
        return q;
    endfunction
endpackage

// File: rtl/sqrt_iter_step.sv
// sqrt_iter_step: one combinational restoring square-root step.
//   i_rem   partial remainder      i_root  partial root
//   i_pair  next two radicand bits
//   o_rem   updated remainder      o_root  root with the new bit appended
module sqrt_iter_step #(
    parameter int R = 54
) (
    input  logic [R+1:0] i_rem,
    input  logic [R-1:0] i_root,
    input  logic [1:0]   i_pair,
    output logic [R+1:0] o_rem,
    output logic [R-1:0] o_root
);
    logic [R+1:0] w_sh, w_trial;
    logic         w_ge;
    logic [1:0]   w_unused;
    // remainder never exceeds 2*root, so its top two bits are zero on entry
    assign w_unused = i_rem[R+1:R];
    assign w_sh     = {i_rem[R-1:0], i_pair};
    assign w_trial  = {i_root, 2'b01};
    assign w_ge     = w_sh >= w_trial;
    assign o_rem    = w_ge ? w_sh - w_trial : w_sh;
    assign o_root   = {i_root[R-2:0], w_ge};
endmodule

// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: IEEE-754 square root, restoring digit recurrence, round-to-nearest-even.
//   clk, rst                  clock, asynchronous active-high reset
//   i_in_valid / o_in_ready   operand handshake, i_in_data = {sign, exp, man}
//   o_out_valid / i_out_ready result handshake, o_out_data = IEEE result
//   o_out_inv / o_out_inx     invalid and inexact flags, held with o_out_data
module fp_sqrt_iter
    import fp_sqrt_pkg::*;
#(
    parameter int EXP_W           = 11,
    parameter int MAN_W           = 52,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [EXP_W+MAN_W:0]     i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [EXP_W+MAN_W:0]     o_out_data,
    output logic                     o_out_inv,
    output logic                     o_out_inx
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int R    = MAN_W + 2;
    localparam int N_IT = f_n_it(MAN_W, STEPS_PER_CYCLE);
    localparam int CW   = $clog2(N_IT + 1);
    localparam int BIAS = f_bias(EXP_W);
    localparam logic [127:0] QNAN_ALL = f_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QNAN_ALL[W-1:0];

    state_t           r_state, w_next;
    logic [W-1:0]     r_op, r_data, w_sp_data;
    logic             r_inv, r_inx, r_spec, w_spec, w_sp_inv;
    logic [EXP_W-1:0] r_exp, w_ex, w_eo;
    logic [CW-1:0]    r_cnt;
    logic [R+1:0]     r_rem;
    logic [R-1:0]     r_root;
    logic [2*R-1:0]   r_rad, w_rad0;
    logic [MAN_W-1:0] w_man;
    logic [MAN_W:0]   w_mr;
    logic             w_sign, w_g, w_st, w_up;

    assign w_sign = r_op[W-1];
    assign w_ex   = r_op[W-2:MAN_W];
    assign w_man  = r_op[MAN_W-1:0];
    // unbiased exponent is odd exactly when the biased one is even (BIAS is odd)
    assign w_rad0 = {1'b1, w_man, {(MAN_W+3){1'b0}}} >> w_ex[0];

    always_comb begin
        w_spec    = 1'b1;
        w_sp_inv  = 1'b0;
        w_sp_data = QNAN;
        if (w_ex == '0)
            w_sp_data = {w_sign, {(W-1){1'b0}}};
        else if (&w_ex && w_man != '0)
            w_sp_inv = ~w_man[MAN_W-1];
        else if (w_sign)
            w_sp_inv = 1'b1;
        else if (&w_ex)
            w_sp_data = r_op;
        else
            w_spec = 1'b0;
    end

    // stages past the R-th root bit pass through when R is not a multiple of STEPS_PER_CYCLE
    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        logic [R+1:0] w_rem_i, w_rem_o, w_srem;
        logic [R-1:0] w_root_i, w_root_o, w_sroot;
        logic         w_en;
        if (g == 0) begin : g_first
            assign w_rem_i  = r_rem;
            assign w_root_i = r_root;
        end else begin : g_next
            assign w_rem_i  = g_step[g-1].w_rem_o;
            assign w_root_i = g_step[g-1].w_root_o;
        end
        assign w_en = int'(r_cnt) * STEPS_PER_CYCLE + g < R;
        sqrt_iter_step #(.R(R)) u_step (
            .i_rem  (w_rem_i),
            .i_root (w_root_i),
            .i_pair (r_rad[2*R-1-2*g -: 2]),
            .o_rem  (w_srem),
            .o_root (w_sroot)
        );
        assign w_rem_o  = w_en ? w_srem : w_rem_i;
        assign w_root_o = w_en ? w_sroot : w_root_i;
    end

    assign w_g  = r_root[0];
    assign w_st = |r_rem;
    assign w_up = w_g & (w_st | r_root[1]);
    assign w_mr = {1'b0, r_root[R-2:1]} + (MAN_W+1)'(w_up);
    assign w_eo = r_exp + EXP_W'(w_mr[MAN_W]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = (r_state == IDLE) && !rst;
        o_out_valid = r_state == DONE;
        case (r_state)
            IDLE:    if (i_in_valid) w_next = PREP;
            PREP:    w_next = w_spec ? ROUND : ITER;
            ITER:    if (r_cnt == CW'(N_IT - 1)) w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    if (i_out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_data <= '0;
            r_inv  <= 1'b0;
            r_inx  <= 1'b0;
            r_spec <= 1'b0;
            r_exp  <= '0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_rad  <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) r_op <= i_in_data;
                PREP: begin
                    r_spec <= w_spec;
                    r_cnt  <= '0;
                    r_rem  <= '0;
                    r_root <= '0;
                    r_rad  <= w_rad0;
                    // floor(e/2)+BIAS == (exp+BIAS)>>1
                    r_exp  <= EXP_W'(({1'b0, w_ex} + (EXP_W+1)'(BIAS)) >> 1);
                    if (w_spec) begin
                        r_data <= w_sp_data;
                        r_inv  <= w_sp_inv;
                        r_inx  <= 1'b0;
                    end
                end
                ITER: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_rem  <= g_step[STEPS_PER_CYCLE-1].w_rem_o;
                    r_root <= g_step[STEPS_PER_CYCLE-1].w_root_o;
                    r_rad  <= r_rad << (2 * STEPS_PER_CYCLE);
                end
                ROUND: if (!r_spec) begin
                    r_data <= {1'b0, w_eo, w_mr[MAN_W-1:0]};
                    r_inv  <= 1'b0;
                    r_inx  <= w_g | w_st;
                end
                default: ;
            endcase
        end
    end

    assign o_out_data = r_data;
    assign o_out_inv  = r_inv;
    assign o_out_inx  = r_inx;
endmodule
